// File: rtl/carpma_birimi_m.sv
// RV32M multiply unit: MUL/MULH/MULHSU/MULHU through one shared multiplier,
// with the selected 32-bit result word registered and a stall that holds it.
module carpma_birimi_m (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        durdur_i,
  input  logic [1:0]  kontrol_i,
  input  logic [31:0] deger1_i,
  input  logic [31:0] deger2_i,
  output logic [31:0] sonuc_o
);

  typedef enum logic [1:0] {
    CARPMA_MUL    = 2'b00,
    CARPMA_MULH   = 2'b01,
    CARPMA_MULHSU = 2'b10,
    CARPMA_MULHU  = 2'b11
  } carpma_op_e;

  carpma_op_e  islem;
  logic        isaret1;
  logic        isaret2;
  logic [63:0] genis1;
  logic [63:0] genis2;
  logic [63:0] carpim;
  logic [31:0] sonuc_d;
  logic [31:0] sonuc_q;

  always_comb begin
    islem   = carpma_op_e'(kontrol_i);
    isaret1 = 1'b0;
    isaret2 = 1'b0;
    case (islem)
      CARPMA_MUL:    begin isaret1 = 1'b1; isaret2 = 1'b1; end
      CARPMA_MULH:   begin isaret1 = 1'b1; isaret2 = 1'b1; end
      CARPMA_MULHSU: begin isaret1 = 1'b1; isaret2 = 1'b0; end
      CARPMA_MULHU:  begin isaret1 = 1'b0; isaret2 = 1'b0; end
      default:       begin isaret1 = 1'b0; isaret2 = 1'b0; end
    endcase
  end

  // Extending straight to 64 bits and keeping the low 64 product bits gives
  // the same [63:0] as the 33x33 signed product, with no unused upper bits.
  always_comb begin
    genis1 = {{32{isaret1 & deger1_i[31]}}, deger1_i};
    genis2 = {{32{isaret2 & deger2_i[31]}}, deger2_i};
    carpim = genis1 * genis2;
  end

  always_comb begin
    sonuc_d = sonuc_q;
    if (!durdur_i) begin
      if (islem == CARPMA_MUL) sonuc_d = carpim[31:0];
      else                     sonuc_d = carpim[63:32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sonuc_q <= '0;
    else       sonuc_q <= sonuc_d;
  end

  assign sonuc_o = sonuc_q;

endmodule

// File: tb/tb_carpma_birimi_m.sv
// Bench for carpma_birimi_m: directed spec vectors plus randomized traffic
// checked against a 64-bit arithmetic reference model.
module tb_carpma_birimi_m;

  logic        clk_i;
  logic        rst_i;
  logic        durdur_i;
  logic [1:0]  kontrol_i;
  logic [31:0] deger1_i;
  logic [31:0] deger2_i;
  logic [31:0] sonuc_o;

  int unsigned total;
  int unsigned bad;
  logic [31:0] beklenen;

  carpma_birimi_m dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .durdur_i  (durdur_i),
    .kontrol_i (kontrol_i),
    .deger1_i  (deger1_i),
    .deger2_i  (deger2_i),
    .sonuc_o   (sonuc_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic kontrol_et(input string tag, input logic [31:0] gozlenen,
                            input logic [31:0] istenen);
    total++;
    if (gozlenen !== istenen) begin
      bad++;
      $display("FAIL %s: got=%08h want=%08h", tag, gozlenen, istenen);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] k,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    logic [31:0]     r;
    case (k)
      2'b00: begin p = longint'(a) * longint'(b); r = p[31:0]; end
      2'b01: begin p = longint'($signed(a)) * longint'($signed(b)); r = p[63:32]; end
      2'b10: begin p = longint'($signed(a)) * longint'(b); r = p[63:32]; end
      default: begin
        pu = longint'(a);
        pu = pu * longint'(b);
        r  = pu[63:32];
      end
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs, clock once, update reference, sample #1 later.
  task automatic adim(input logic [1:0] k, input logic [31:0] a,
                      input logic [31:0] b, input logic st, input logic rs);
    kontrol_i = k;
    deger1_i  = a;
    deger2_i  = b;
    durdur_i  = st;
    rst_i     = rs;
    @(posedge clk_i);
    if (rs)       beklenen = '0;
    else if (!st) beklenen = model(k, a, b);
    #1;
  endtask

  task automatic yonlu(input string tag, input logic [1:0] k, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] istenen);
    adim(k, a, b, 1'b0, 1'b0);
    kontrol_et(tag, sonuc_o, istenen);
  endtask

  function automatic logic [31:0] rastgele_deger();
    logic [31:0] v;
    case ($urandom_range(7))
      0: v = 32'h0000_0000;
      1: v = 32'hFFFF_FFFF;
      2: v = 32'h8000_0000;
      3: v = 32'h7FFF_FFFF;
      4: v = 32'h0000_0001;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    total    = 0;
    bad      = 0;
    beklenen = '0;
    rst_i    = 1'b1;
    durdur_i = 1'b0;
    kontrol_i = 2'b00;
    deger1_i = 32'd7;
    deger2_i = 32'd9;

    adim(2'b00, 32'd7, 32'd9, 1'b0, 1'b1);
    kontrol_et("reset1", sonuc_o, 32'h0);
    adim(2'b01, 32'hFFFF_FFFF, 32'd9, 1'b1, 1'b1);
    kontrol_et("reset2", sonuc_o, 32'h0);
    yonlu("mul_140x40", 2'b00, 32'd140, 32'd40, 32'd5600);

    yonlu("mul_140xm40",  2'b00, 32'd140, -32'sd40, 32'hFFFF_EA20);
    yonlu("mul_m140x40",  2'b00, -32'sd140, 32'd40, 32'hFFFF_EA20);
    yonlu("mul_wrap",     2'b00, 32'h0F00_0000, 32'h0F00_0000, 32'h0);
    yonlu("mul_140xm1",   2'b00, 32'd140, 32'hFFFF_FFFF, -32'sd140);
    yonlu("mul_m140x0",   2'b00, -32'sd140, 32'd0, 32'h0);

    yonlu("mulh_pos",     2'b01, 32'h0011_0000, 32'h0003_0000, 32'd51);
    yonlu("mulh_xm1",     2'b01, 32'h0011_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    yonlu("mulh_m1x",     2'b01, 32'hFFFF_FFFF, 32'h0011_0000, 32'hFFFF_FFFF);
    yonlu("mulh_zero",    2'b01, 32'h1234_5678, 32'h0, 32'h0);

    yonlu("mulhu_pos",    2'b11, 32'h0011_0000, 32'h0003_0000, 32'd51);
    yonlu("mulhu_xff",    2'b11, 32'h0011_0000, 32'hFFFF_FFFF, 32'h0010_FFFF);
    yonlu("mulhu_ffx",    2'b11, 32'hFFFF_FFFF, 32'h0011_0000, 32'h0010_FFFF);
    yonlu("mulhu_zero",   2'b11, 32'h1234_5678, 32'h0, 32'h0);

    yonlu("mulhsu_pos",   2'b10, 32'h0011_0000, 32'h0003_0000, 32'd51);
    yonlu("mulhsu_xff",   2'b10, 32'h0011_0000, 32'hFFFF_FFFF, 32'h0010_FFFF);
    yonlu("mulhsu_m1x",   2'b10, 32'hFFFF_FFFF, 32'h0011_0000, 32'hFFFF_FFFF);
    yonlu("mulhsu_zero",  2'b10, 32'h1234_5678, 32'h0, 32'h0);

    yonlu("stall_pre", 2'b00, 32'd140, 32'd40, 32'd5600);
    for (int i = 0; i < 3; i++) begin
      adim(2'b00, 32'd3, 32'd3, 1'b1, 1'b0);
      kontrol_et("stall_hold", sonuc_o, 32'd5600);
    end
    yonlu("stall_release", 2'b00, 32'd3, 32'd3, 32'd9);
    adim(2'b00, 32'd5, 32'd5, 1'b1, 1'b1);
    kontrol_et("rst_over_stall", sonuc_o, 32'h0);
    yonlu("after_rst", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    for (int n = 0; n < 400; n++) begin
      adim(2'($urandom_range(3)), rastgele_deger(), rastgele_deger(),
           ($urandom_range(7) == 0), ($urandom_range(31) == 0));
      kontrol_et("random", sonuc_o, beklenen);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
